// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the pipeline hazard/forwarding logic:
//     REG_W                     register-index width
//     FWD_RF/FWD_EXMEM/FWD_MEMWB operand-select encodings for fwd_a/fwd_b
//     slot_t                    shadow copy of an in-flight destination
//     idx_hit()                 register match that never fires on r0
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             we;
      logic             load;
   } slot_t;

   localparam slot_t SLOT_BUBBLE = '{rd: '0, we: 1'b0, load: 1'b0};

   // r0 is hard-wired zero, so a write to it is never a real producer.
   function automatic logic idx_hit(logic [REG_W-1:0] dst, logic [REG_W-1:0] src);
      return (dst != '0) && (dst == src);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle between the ID-stage datapath and hazard_ctrl.
//   Handshake: there is no valid/ready pair here; id_valid qualifies the ID
//   decode fields in the same cycle, and stall is the back-pressure answer
//   in that same cycle (combinational). An instruction issues into EX on a
//   rising edge where id_valid=1, stall=0 and flush=0.
//   master : datapath side (drives ID fields and flush, reads controls)
//   slave  : hazard_ctrl side
// ----------------------------------------------------------------------------
interface hazard_ctrl_if;
   import cpu_pkg::*;

   logic             id_valid;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_store;
   logic [REG_W-1:0] id_rd;
   logic             id_we;
   logic             id_load;
   logic             id_md_start;
   logic             id_md_read;
   logic             flush;
   logic             stall;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic             redir_dm;
   logic             md_busy;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_store,
             id_rd, id_we, id_load, id_md_start, id_md_read, flush,
      input  stall, fwd_a, fwd_b, redir_dm, md_busy
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_store,
             id_rd, id_we, id_load, id_md_start, id_md_read, flush,
      output stall, fwd_a, fwd_b, redir_dm, md_busy
   );

endinterface

// File: rtl/md_busy_cnt.sv
// ----------------------------------------------------------------------------
// md_busy_cnt
//   Mult/div busy countdown. Loads on start, otherwise decrements and
//   saturates at zero.
//   Ports: clk, rst_n (async active-low), start (mult/div issues this edge),
//          busy (count non-zero).
//   The issue cycle itself is the first of the MD_LAT busy cycles, so the
//   register holds the number of busy cycles still to come: MD_LAT-1 at load.
//   With MD_LAT=4 a dependent mflo right behind the mult waits 3 cycles and
//   busy drops after the third edge following the issue edge.
// ----------------------------------------------------------------------------
module md_busy_cnt #(
   parameter int MD_LAT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy
);

   localparam logic [3:0] LOAD_VAL = 4'(MD_LAT - 1);

   logic [3:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= LOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   ID-stage hazard detection and forwarding control. Keeps its own shadow of
//   the EX and MEM destinations so the datapath only supplies ID decode fields.
//   Ports: clk, rst_n (async active-low), hz (hazard_ctrl_if.slave):
//     stall    combinational: hold PC and IF/ID, bubble into EX
//     fwd_a/b  registered operand selects for the instruction now in EX
//     redir_dm registered: store data comes from the load result in WB
//     md_busy  mult/div countdown non-zero
// ----------------------------------------------------------------------------
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int MD_LAT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  hz
);

   slot_t            ex_q;
   logic [REG_W-1:0] mem_rd_q;
   logic             mem_we_q;
   logic [1:0]       fwd_a_q;
   logic [1:0]       fwd_b_q;
   logic             redir_q;

   logic load_use;
   logic md_stall;
   logic stall_c;
   logic issue;
   logic md_busy_w;

   // EX result beats MEM result; a load in EX has no data yet, so it is
   // never a forwarding source (that case is a stall or a store redirect).
   function automatic logic [1:0] fwd_sel(slot_t ex, logic [REG_W-1:0] m_rd,
                                          logic m_we, logic [REG_W-1:0] src);
      if (ex.we && !ex.load && idx_hit(ex.rd, src)) return FWD_EXMEM;
      if (m_we && idx_hit(m_rd, src))               return FWD_MEMWB;
      return FWD_RF;
   endfunction

   always_comb begin
      load_use = ex_q.load && ex_q.we &&
                 ((hz.id_use_rs && idx_hit(ex_q.rd, hz.id_rs)) ||
                  (hz.id_use_rt && idx_hit(ex_q.rd, hz.id_rt)));
      md_stall = md_busy_w && (hz.id_md_read || hz.id_md_start);
      // flush wins: the instruction is being killed, nothing to wait for.
      stall_c  = hz.id_valid && !hz.flush && (load_use || md_stall);
      issue    = hz.id_valid && !hz.flush && !stall_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q     <= SLOT_BUBBLE;
         mem_rd_q <= '0;
         mem_we_q <= 1'b0;
         fwd_a_q  <= FWD_RF;
         fwd_b_q  <= FWD_RF;
         redir_q  <= 1'b0;
      end else begin
         mem_rd_q <= ex_q.rd;
         mem_we_q <= ex_q.we;
         if (issue) begin
            ex_q    <= '{rd: hz.id_rd, we: hz.id_we, load: hz.id_load};
            fwd_a_q <= fwd_sel(ex_q, mem_rd_q, mem_we_q, hz.id_rs);
            fwd_b_q <= fwd_sel(ex_q, mem_rd_q, mem_we_q, hz.id_rt);
            // Store data needs the loaded value one stage later, in WB,
            // so the store goes ahead without a stall.
            redir_q <= hz.id_store && ex_q.load && idx_hit(ex_q.rd, hz.id_rt);
         end else begin
            ex_q    <= SLOT_BUBBLE;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            redir_q <= 1'b0;
         end
      end
   end

   md_busy_cnt #(.MD_LAT(MD_LAT)) u_md_busy_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .start (issue && hz.id_md_start),
      .busy  (md_busy_w)
   );

   assign hz.stall    = stall_c;
   assign hz.fwd_a    = fwd_a_q;
   assign hz.fwd_b    = fwd_b_q;
   assign hz.redir_dm = redir_q;
   assign hz.md_busy  = md_busy_w;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed instruction sequences against hazard_ctrl (MD_LAT=4) with
//   hand-computed expectations. Inputs change 1ns after a rising edge,
//   outputs are sampled 2ns after it.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;
   import cpu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   hazard_ctrl_if hz();

   hazard_ctrl #(.MD_LAT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // checker
   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drivers
   task automatic idle();
      hz.id_valid    = 1'b0;
      hz.id_rs       = '0;
      hz.id_rt       = '0;
      hz.id_use_rs   = 1'b0;
      hz.id_use_rt   = 1'b0;
      hz.id_store    = 1'b0;
      hz.id_rd       = '0;
      hz.id_we       = 1'b0;
      hz.id_load     = 1'b0;
      hz.id_md_start = 1'b0;
      hz.id_md_read  = 1'b0;
      hz.flush       = 1'b0;
   endtask

   task automatic instr(input int rs, input int rt, input logic use_rs, input logic use_rt,
                        input logic store, input int rd, input logic we, input logic load,
                        input logic md_start, input logic md_read);
      idle();
      hz.id_valid    = 1'b1;
      hz.id_rs       = REG_W'(rs);
      hz.id_rt       = REG_W'(rt);
      hz.id_use_rs   = use_rs;
      hz.id_use_rt   = use_rt;
      hz.id_store    = store;
      hz.id_rd       = REG_W'(rd);
      hz.id_we       = we;
      hz.id_load     = load;
      hz.id_md_start = md_start;
      hz.id_md_read  = md_read;
      #1;
   endtask

   // Advance one edge; returns 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      idle();
      rst_n = 1'b0;
      #3;
      check("rst_stall", {3'b0, hz.stall}, 4'h0);
      check("rst_fwd_a", {2'b0, hz.fwd_a}, 4'h0);
      check("rst_fwd_b", {2'b0, hz.fwd_b}, 4'h0);
      check("rst_redir", {3'b0, hz.redir_dm}, 4'h0);
      check("rst_md_busy", {3'b0, hz.md_busy}, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // lw r2 ; add r3,r2,r4 -> one stall cycle, then forward from MEM/WB
      instr(0, 0, 1, 0, 0, 2, 1, 1, 0, 0);
      check("lw_no_stall", {3'b0, hz.stall}, 4'h0);
      tick();
      instr(2, 4, 1, 1, 0, 3, 1, 0, 0, 0);
      check("lu_stall", {3'b0, hz.stall}, 4'h1);
      tick();
      #1;
      check("lu_release", {3'b0, hz.stall}, 4'h0);
      check("lu_bubble_fwd", {2'b0, hz.fwd_a}, 4'h0);
      tick();
      check("lu_fwd_a", {2'b0, hz.fwd_a}, {2'b0, FWD_MEMWB});
      check("lu_fwd_b", {2'b0, hz.fwd_b}, {2'b0, FWD_RF});

      // add r5,r8,r9 ; sub r6,r5,r5 -> EX/MEM forward on both operands
      instr(8, 9, 1, 1, 0, 5, 1, 0, 0, 0);
      tick();
      instr(5, 5, 1, 1, 0, 6, 1, 0, 0, 0);
      check("alu_no_stall", {3'b0, hz.stall}, 4'h0);
      tick();
      check("alu_fwd_a", {2'b0, hz.fwd_a}, {2'b0, FWD_EXMEM});
      check("alu_fwd_b", {2'b0, hz.fwd_b}, {2'b0, FWD_EXMEM});
      // rs=r5 (now in MEM), rt=r6 (now in EX), no destination
      instr(5, 6, 1, 1, 0, 0, 0, 0, 0, 0);
      tick();
      check("mix_fwd_a", {2'b0, hz.fwd_a}, {2'b0, FWD_MEMWB});
      check("mix_fwd_b", {2'b0, hz.fwd_b}, {2'b0, FWD_EXMEM});

      // lw r7,0(r1) ; sw r7,0(r1) -> no stall, redirect store data
      instr(1, 0, 1, 0, 0, 7, 1, 1, 0, 0);
      tick();
      instr(1, 7, 1, 0, 1, 0, 0, 0, 0, 0);
      check("st_no_stall", {3'b0, hz.stall}, 4'h0);
      tick();
      check("st_redir", {3'b0, hz.redir_dm}, 4'h1);
      check("st_fwd_a", {2'b0, hz.fwd_a}, 4'h0);
      check("st_fwd_b", {2'b0, hz.fwd_b}, 4'h0);
      idle();
      tick();
      check("st_redir_drop", {3'b0, hz.redir_dm}, 4'h0);

      // lw r0 ; add r3,r0,r0 -> r0 never hazards
      instr(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
      tick();
      instr(0, 0, 1, 1, 0, 3, 1, 0, 0, 0);
      check("r0_no_stall", {3'b0, hz.stall}, 4'h0);
      tick();
      check("r0_fwd_a", {2'b0, hz.fwd_a}, 4'h0);
      check("r0_fwd_b", {2'b0, hz.fwd_b}, 4'h0);

      // lw r9 ; add using r9 with flush -> flush wins
      instr(0, 0, 1, 0, 0, 9, 1, 1, 0, 0);
      tick();
      instr(9, 0, 1, 0, 0, 10, 1, 0, 0, 0);
      hz.flush = 1'b1;
      #1;
      check("fl_no_stall", {3'b0, hz.stall}, 4'h0);
      tick();
      check("fl_fwd_a", {2'b0, hz.fwd_a}, 4'h0);
      idle();
      tick();

      // mult ; mflo next cycle -> 3 stall cycles
      check("md_idle", {3'b0, hz.md_busy}, 4'h0);
      instr(10, 11, 1, 1, 0, 0, 0, 0, 1, 0);
      check("mult_no_stall", {3'b0, hz.stall}, 4'h0);
      tick();
      check("mult_busy", {3'b0, hz.md_busy}, 4'h1);
      instr(0, 0, 0, 0, 0, 12, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("md_stall_%0d", i), {3'b0, hz.stall}, 4'h1);
         tick();
      end
      check("md_busy_fall", {3'b0, hz.md_busy}, 4'h0);
      check("md_release", {3'b0, hz.stall}, 4'h0);
      tick();

      // mult ; 4 idle ; mflo -> no stall
      instr(10, 11, 1, 1, 0, 0, 0, 0, 1, 0);
      tick();
      idle();
      for (int i = 0; i < 4; i++) tick();
      instr(0, 0, 0, 0, 0, 12, 1, 0, 0, 1);
      check("md_late_no_stall", {3'b0, hz.stall}, 4'h0);
      tick();

      // flush does not abort the countdown
      instr(10, 11, 1, 1, 0, 0, 0, 0, 1, 0);
      tick();
      instr(0, 0, 0, 0, 0, 12, 1, 0, 0, 1);
      hz.flush = 1'b1;
      #1;
      check("md_flush_no_stall", {3'b0, hz.stall}, 4'h0);
      tick();
      check("md_flush_busy", {3'b0, hz.md_busy}, 4'h1);
      idle();
      for (int i = 0; i < 3; i++) tick();

      // reset in the middle of a load-use stall with live fwd and md state
      instr(0, 0, 0, 0, 0, 13, 1, 0, 0, 0);
      tick();
      instr(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      instr(13, 0, 1, 0, 0, 2, 1, 1, 0, 0);
      tick();
      instr(2, 0, 1, 0, 0, 3, 1, 0, 0, 0);
      check("pre_rst_stall", {3'b0, hz.stall}, 4'h1);
      check("pre_rst_fwd_a", {2'b0, hz.fwd_a}, {2'b0, FWD_MEMWB});
      check("pre_rst_busy", {3'b0, hz.md_busy}, 4'h1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_stall", {3'b0, hz.stall}, 4'h0);
      check("mid_rst_fwd_a", {2'b0, hz.fwd_a}, 4'h0);
      check("mid_rst_redir", {3'b0, hz.redir_dm}, 4'h0);
      check("mid_rst_busy", {3'b0, hz.md_busy}, 4'h0);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
